sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 26 ++
 rtl/sram_arbiter_if.sv | 52 +++++
 rtl/sram_arb_pick.sv | 46 ++++
 rtl/sram_arbiter.sv | 103 ++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter: bus widths, FSM state
// encoding, arbitration mode codes and requester identifiers.
package sram_arb_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE_RR     = 2'b00,
    MODE_A_ONLY = 2'b01,
    MODE_B_ONLY = 2'b10,
    MODE_A_PRIO = 2'b11
  } mode_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two requesters, the SRAM macro and the arbiter.
//   mode                 : arbitration mode (00 RR, 01 A only, 10 B only, 11 A prio)
//   a_* / b_*            : per-requester req/addr/wdata/we in, ack/rdata out
//   mem_*                : SRAM side (active-low cen/gwen, addr, wdata out, q in)
//   busy                 : arbiter has a transaction in flight
// Modport slave is the arbiter's view, master is the environment's view.
interface sram_arbiter_if;
  import sram_arb_pkg::*;

  logic [1:0]        mode;
  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_we;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;
  logic              b_req;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_we;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;
  logic              mem_cen;
  logic              mem_gwen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_q;
  logic              busy;

  modport slave (
    input  mode,
    input  a_req, a_addr, a_wdata, a_we,
    output a_ack, a_rdata,
    input  b_req, b_addr, b_wdata, b_we,
    output b_ack, b_rdata,
    output mem_cen, mem_gwen, mem_addr, mem_wdata,
    input  mem_q,
    output busy
  );

  modport master (
    output mode,
    output a_req, a_addr, a_wdata, a_we,
    input  a_ack, a_rdata,
    output b_req, b_addr, b_wdata, b_we,
    input  b_ack, b_rdata,
    input  mem_cen, mem_gwen, mem_addr, mem_wdata,
    output mem_q,
    input  busy
  );

endinterface

// File: rtl/sram_arb_pick.sv
// Combinational grant selection.
//   a_req, b_req : raw request levels
//   mode         : arbitration mode
//   last_grant   : requester granted most recently (round-robin history)
//   grant_valid  : an eligible request exists
//   grant_id     : which requester wins (meaningful only with grant_valid)
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic       a_req,
  input  logic       b_req,
  input  logic [1:0] mode,
  input  req_id_e    last_grant,
  output logic       grant_valid,
  output req_id_e    grant_id
);

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ_A;
    case (mode)
      MODE_A_ONLY: begin
        grant_valid = a_req;
        grant_id    = REQ_A;
      end
      MODE_B_ONLY: begin
        grant_valid = b_req;
        grant_id    = REQ_B;
      end
      MODE_A_PRIO: begin
        grant_valid = a_req | b_req;
        grant_id    = a_req ? REQ_A : REQ_B;
      end
      default: begin
        grant_valid = a_req | b_req;
        // Only a genuine tie consults history; a lone requester always wins.
        if (a_req && b_req) begin
          grant_id = (last_grant == REQ_A) ? REQ_B : REQ_A;
        end else begin
          grant_id = a_req ? REQ_A : REQ_B;
        end
      end
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous SRAM.
// Each transaction takes IDLE (grant + latch) -> ACCESS (SRAM strobe) ->
// RESP (ack + read data), so a request sampled at cycle N is acked at N+2.
//   wb_clk_i : clock
//   wb_rst_i : synchronous active-high reset
//   bus      : requester / SRAM bundle, arbiter side
module sram_arbiter
  import sram_arb_pkg::*;
(
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  sram_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  req_id_e           last_grant_q, last_grant_d;
  req_id_e           id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;

  logic              grant_valid;
  req_id_e           grant_id;

  logic              in_access;
  logic              in_resp;
  logic              a_sel;
  logic              b_sel;

  sram_arb_pick u_pick (
    .a_req       (bus.a_req),
    .b_req       (bus.b_req),
    .mode        (bus.mode),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Mode and requests are only looked at in IDLE, so anything that changes
  // while a transaction is in flight cannot disturb it.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d      = ST_ACCESS;
          last_grant_d = grant_id;
          id_d         = grant_id;
          addr_d       = (grant_id == REQ_A) ? bus.a_addr  : bus.b_addr;
          wdata_d      = (grant_id == REQ_A) ? bus.a_wdata : bus.b_wdata;
          we_d         = (grant_id == REQ_A) ? bus.a_we    : bus.b_we;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ_B;
      id_q         <= REQ_A;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
    end
  end

  // Outputs decode straight from the state flops; reset masks them in the
  // same cycle so an aborted access never strobes the SRAM or acks.
  assign in_access = (state_q == ST_ACCESS) && !wb_rst_i;
  assign in_resp   = (state_q == ST_RESP)   && !wb_rst_i;
  assign a_sel     = in_resp && (id_q == REQ_A);
  assign b_sel     = in_resp && (id_q == REQ_B);

  assign bus.mem_cen   = ~in_access;
  assign bus.mem_gwen  = ~(in_access && we_q);
  assign bus.mem_addr  = in_access ? addr_q  : '0;
  assign bus.mem_wdata = in_access ? wdata_q : '0;

  // mem_q is valid the cycle after the strobe, which is exactly RESP.
  assign bus.a_ack   = a_sel;
  assign bus.a_rdata = (a_sel && !we_q) ? bus.mem_q : '0;
  assign bus.b_ack   = b_sel;
  assign bus.b_rdata = (b_sel && !we_q) ? bus.mem_q : '0;

  assign bus.busy = in_access | in_resp;

endmodule
